ahb_lite_dual_master_arbiter: RTL and testbench
===============================================

Name: ahb_lite_dual_master_arbiter

Overview:
- Shares one AHB-Lite slave port between two AHB-Lite masters (M0, M1), typically the AHB side of the AHB-to-APB bridge.
- Captures each master's address phase into a holding register and stalls that master's data phase (its HREADY held low) until the downstream transfer completes.
- Issues captured requests downstream one at a time as NONSEQ single transfers, with round-robin arbitration and pipelined address/data phases.

Parameters:
AHB_ADDR_WIDTH, 32, address width on all ports
AHB_DATA_WIDTH, 64, data width on all ports

Ports:
hclk_i  in  1  clock
hreset_ni  in  1  asynchronous active-low reset
mX_haddr_i  in  AHB_ADDR_WIDTH  master X address (X=0,1; likewise for all mX_ ports)
mX_htrans_i  in  2  master X transfer type
mX_hwrite_i  in  1  master X write
mX_hsize_i  in  3  master X size
mX_hwdata_i  in  AHB_DATA_WIDTH  master X write data
mX_hreadyout_o  out  1  master X HREADY
mX_hresp_o  out  1  master X error response
mX_hrdata_o  out  AHB_DATA_WIDTH  master X read data
s_hsel_o  out  1  downstream select
s_haddr_o  out  AHB_ADDR_WIDTH  downstream address
s_htrans_o  out  2  downstream transfer type
s_hwrite_o  out  1  downstream write
s_hsize_o  out  3  downstream size
s_hwdata_o  out  AHB_DATA_WIDTH  downstream write data
s_hready_o  out  1  downstream HREADY input to slave
s_hreadyout_i  in  1  downstream slave HREADYOUT
s_hresp_i  in  1  downstream slave error
s_hrdata_i  in  AHB_DATA_WIDTH  downstream read data

Behaviour:
- Reset: hreset_ni is asynchronous and active-low on hclk_i. During reset mX_hreadyout_o=1, mX_hresp_o=0, s_hsel_o=0, s_htrans_o=IDLE (2'b00). All pend, aph and dph state is cleared and the round-robin pointer selects M0 first. Reset asserted mid-transfer abandons the transfer; no completion is signalled.
- Capture: when mX_htrans_i is NONSEQ or SEQ and mX_hreadyout_o=1, latch haddr/hwrite/hsize into hold[X] and set pend[X]. IDLE and BUSY are never captured. Each master has at most one outstanding request.
- mX_hreadyout_o = !pend[X] OR (dph_valid AND dph_owner==X AND s_hreadyout_i). This is combinational.
- Pipeline registers:
  - aph: valid, owner. Holds the downstream address phase.
  - dph: valid, owner. Holds the downstream data phase.
  - Update only when s_hreadyout_i=1: dph <= aph, then aph <= new grant.
  - While s_hreadyout_i=0, aph and dph are frozen, so address and control stay stable as AHB requires.
- Candidate X: pend[X] AND X is not aph_owner (when aph valid) AND X is not dph_owner (when dph valid).
- Arbitration: with one candidate, grant it. With two candidates, grant the master other than last_grant. last_grant updates on each grant.
- Downstream address phase:
  - s_htrans_o = aph_valid ? NONSEQ : IDLE. SEQ is always re-issued as NONSEQ.
  - s_hsel_o = aph_valid.
  - s_haddr_o, s_hwrite_o, s_hsize_o come from hold[aph_owner].
- Downstream data phase: s_hwdata_o = mX_hwdata_i of dph_owner (the master holds hwdata while stalled); otherwise 0.
- s_hready_o = s_hreadyout_i (single slave).
- Completion: dph valid with s_hreadyout_i=1 clears pend[dph_owner]. In the same cycle the owner sees hreadyout=1 and may present a new address, captured per the Capture rule.
- Read data: mX_hrdata_o = s_hrdata_i, broadcast to both masters. Only the owner's hreadyout qualifies it.
- Error: mX_hresp_o = dph_valid AND dph_owner==X AND s_hresp_i. The two-cycle ERROR response passes through: first cycle hresp=1 with hready=0, second cycle hresp=1 with hready=1. The other master's request already in aph is still issued.
- Latency: for an idle arbiter with a zero-wait slave, address captured in cycle N goes downstream in N+1 and completes in N+2 (one extra wait state). Worst-case wait for a contending master is one transfer of the other master.

Test Plan:
- Reset then idle: mX_hreadyout_o=1, s_htrans_o=0, s_hsel_o=0; M0 IDLE/BUSY is never captured, s_htrans_o stays 0.
- M0 single write to 0x1000, hsize=2, hwdata=0xA5A5, zero-wait slave -> s_haddr_o=0x1000 NONSEQ in N+1; s_hwdata_o=0xA5A5 in N+2; m0_hreadyout_o low in N+1, high in N+2.
- M0 and M1 reads captured in the same cycle (0x10, 0x20) -> M0 issued first, then M1 back-to-back; next simultaneous pair issues M1 first (round-robin).
- Slave inserts 3 wait states on an M1 read with a pending M0 request in aph -> s_haddr_o/s_htrans_o stay stable for 3 cycles; m1_hrdata_o is valid when m1_hreadyout_o rises.
- Slave ERROR on an M0 write -> m0_hresp_o=1 for 2 cycles, m0_hreadyout_o=0 then 1; m1_hresp_o stays 0.
- hreset_ni pulsed low while an M1 request is in dph -> outputs immediately at reset values; no M1 completion afterwards.

Source files
------------

// File: rtl/ahb_lite_dual_master_arbiter.sv
// -----------------------------------------------------------------------------
// ahb_lite_dual_master_arbiter
//
// Purpose:
//   Lets two AHB-Lite masters (M0, M1) share one AHB-Lite slave port, which is
//   typically the AHB side of an AHB-to-APB bridge. Each master's address phase
//   is captured into a per-master holding register. That master's data phase is
//   then stalled (its HREADYOUT is held low) until the downstream transfer
//   completes. Captured requests go downstream one at a time as NONSEQ single
//   transfers. Arbitration is round-robin, and the downstream address and data
//   phases are pipelined.
//
// Ports:
//   hclk_i, hreset_ni        clock, asynchronous active-low reset
//   mX_haddr_i  ..hwdata_i   master X (X = 0,1) address/control/write data
//   mX_hreadyout_o           master X HREADY (low while its request is pending)
//   mX_hresp_o               master X error response
//   mX_hrdata_o              read data (broadcast; qualified by mX_hreadyout_o)
//   s_hsel_o .. s_hwdata_o   downstream address/control/write data
//   s_hready_o               HREADY input to the downstream slave
//   s_hreadyout_i            downstream slave HREADYOUT
//   s_hresp_i, s_hrdata_i    downstream slave response and read data
// -----------------------------------------------------------------------------
module ahb_lite_dual_master_arbiter #(
  parameter int unsigned AHB_ADDR_WIDTH = 32,
  parameter int unsigned AHB_DATA_WIDTH = 64
) (
  input  logic                      hclk_i,
  input  logic                      hreset_ni,

  // Master 0
  input  logic [AHB_ADDR_WIDTH-1:0] m0_haddr_i,
  input  logic [1:0]                m0_htrans_i,
  input  logic                      m0_hwrite_i,
  input  logic [2:0]                m0_hsize_i,
  input  logic [AHB_DATA_WIDTH-1:0] m0_hwdata_i,
  output logic                      m0_hreadyout_o,
  output logic                      m0_hresp_o,
  output logic [AHB_DATA_WIDTH-1:0] m0_hrdata_o,

  // Master 1
  input  logic [AHB_ADDR_WIDTH-1:0] m1_haddr_i,
  input  logic [1:0]                m1_htrans_i,
  input  logic                      m1_hwrite_i,
  input  logic [2:0]                m1_hsize_i,
  input  logic [AHB_DATA_WIDTH-1:0] m1_hwdata_i,
  output logic                      m1_hreadyout_o,
  output logic                      m1_hresp_o,
  output logic [AHB_DATA_WIDTH-1:0] m1_hrdata_o,

  // Downstream slave
  output logic                      s_hsel_o,
  output logic [AHB_ADDR_WIDTH-1:0] s_haddr_o,
  output logic [1:0]                s_htrans_o,
  output logic                      s_hwrite_o,
  output logic [2:0]                s_hsize_o,
  output logic [AHB_DATA_WIDTH-1:0] s_hwdata_o,
  output logic                      s_hready_o,
  input  logic                      s_hreadyout_i,
  input  logic                      s_hresp_i,
  input  logic [AHB_DATA_WIDTH-1:0] s_hrdata_i
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // ---------------------------------------------------------------------------
  // Per-master views of the input ports, so that the rest of the logic can be
  // written once and indexed by master number.
  // ---------------------------------------------------------------------------
  logic [AHB_ADDR_WIDTH-1:0] w_haddr  [2];
  logic [1:0]                w_htrans [2];
  logic [1:0]                w_hwrite;
  logic [2:0]                w_hsize  [2];
  logic [AHB_DATA_WIDTH-1:0] w_hwdata [2];

  assign w_haddr[0]  = m0_haddr_i;
  assign w_haddr[1]  = m1_haddr_i;
  assign w_htrans[0] = m0_htrans_i;
  assign w_htrans[1] = m1_htrans_i;
  assign w_hwrite    = {m1_hwrite_i, m0_hwrite_i};
  assign w_hsize[0]  = m0_hsize_i;
  assign w_hsize[1]  = m1_hsize_i;
  assign w_hwdata[0] = m0_hwdata_i;
  assign w_hwdata[1] = m1_hwdata_i;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [AHB_ADDR_WIDTH-1:0] r_hold_addr [2];
  logic [1:0]                r_hold_write;
  logic [2:0]                r_hold_size [2];
  logic [1:0]                r_pend;        // request captured, not yet completed
  logic                      r_aph_valid;   // downstream address phase occupied
  logic                      r_aph_owner;
  logic                      r_dph_valid;   // downstream data phase occupied
  logic                      r_dph_owner;
  logic                      r_last_grant;  // master granted most recently

  // ---------------------------------------------------------------------------
  // Per-master request handling and candidate selection
  // ---------------------------------------------------------------------------
  logic [1:0] w_complete;   // this master's data phase finishes this cycle
  logic [1:0] w_hreadyout;
  logic [1:0] w_capture;    // address phase being accepted this cycle
  logic [1:0] w_req;
  logic [1:0] w_cand;

  // NOTE: every signal driven in always_comb gets a default at the top of the
  // block, so that no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_complete  = '0;
    w_hreadyout = '0;
    w_capture   = '0;
    w_req       = '0;
    w_cand      = '0;
    for (int i = 0; i < 2; i++) begin
      w_complete[i]  = r_dph_valid && (r_dph_owner == 1'(i)) && s_hreadyout_i;
      w_hreadyout[i] = !r_pend[i] || w_complete[i];
      // NONSEQ (10) and SEQ (11) both have bit 1 set. IDLE and BUSY never do.
      w_capture[i]   = w_htrans[i][1] && w_hreadyout[i];
      // A request captured in this cycle competes straight away. An idle
      // arbiter can therefore issue it downstream in the very next cycle.
      w_req[i]       = r_pend[i] || w_capture[i];
      w_cand[i]      = w_req[i]
                       && !(r_aph_valid && (r_aph_owner == 1'(i)))
                       && !(r_dph_valid && (r_dph_owner == 1'(i)));
    end
  end

  // Round-robin: with a single candidate, that candidate wins. When both
  // masters are candidates, the one not granted last time wins.
  logic w_grant_valid;
  logic w_grant_owner;

  assign w_grant_valid = |w_cand;
  assign w_grant_owner = (&w_cand) ? ~r_last_grant : w_cand[1];

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  // NOTE: all state here uses non-blocking assignments, so every register
  // samples the values from before the clock edge. For example, dph picks up
  // the old aph while aph takes the new grant.
  always_ff @(posedge hclk_i or negedge hreset_ni) begin
    if (!hreset_ni) begin
      // NOTE: the holding registers are reset too. They are only two small
      // entries, and a defined reset value keeps s_haddr_o/s_hsize_o free of
      // X values while the downstream port is idle.
      for (int i = 0; i < 2; i++) begin
        r_hold_addr[i] <= '0;
        r_hold_size[i] <= '0;
      end
      r_hold_write <= '0;
      r_pend       <= '0;
      r_aph_valid  <= 1'b0;
      r_aph_owner  <= 1'b0;
      r_dph_valid  <= 1'b0;
      r_dph_owner  <= 1'b0;
      r_last_grant <= 1'b1;  // M0 wins the first contended arbitration
    end else begin
      for (int i = 0; i < 2; i++) begin
        // A capture happens only when the hold entry is free or is completing
        // from dph. The entry feeding the downstream address phase is never
        // overwritten.
        if (w_capture[i]) begin
          r_hold_addr[i]  <= w_haddr[i];
          r_hold_write[i] <= w_hwrite[i];
          r_hold_size[i]  <= w_hsize[i];
          r_pend[i]       <= 1'b1;
        end else if (w_complete[i]) begin
          r_pend[i]       <= 1'b0;
        end
      end

      // The pipeline advances only when the slave accepts the current phase.
      // Otherwise address and control stay frozen.
      if (s_hreadyout_i) begin
        r_dph_valid <= r_aph_valid;
        r_dph_owner <= r_aph_owner;
        r_aph_valid <= w_grant_valid;
        if (w_grant_valid) begin
          r_aph_owner  <= w_grant_owner;
          r_last_grant <= w_grant_owner;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Downstream port
  // ---------------------------------------------------------------------------
  // SEQ from a master is always re-issued as NONSEQ. Every downstream transfer
  // is a single transfer.
  assign s_hsel_o   = r_aph_valid;
  assign s_htrans_o = r_aph_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign s_haddr_o  = r_hold_addr[r_aph_owner];
  assign s_hwrite_o = r_hold_write[r_aph_owner];
  assign s_hsize_o  = r_hold_size[r_aph_owner];
  // The data-phase master keeps its hwdata stable while it is stalled, so its
  // hwdata can be passed straight through.
  assign s_hwdata_o = r_dph_valid ? w_hwdata[r_dph_owner] : '0;
  assign s_hready_o = s_hreadyout_i;

  // ---------------------------------------------------------------------------
  // Upstream responses
  // ---------------------------------------------------------------------------
  assign m0_hreadyout_o = w_hreadyout[0];
  assign m1_hreadyout_o = w_hreadyout[1];
  // Both cycles of a two-cycle ERROR response pass through to the owner.
  assign m0_hresp_o     = r_dph_valid && !r_dph_owner && s_hresp_i;
  assign m1_hresp_o     = r_dph_valid &&  r_dph_owner && s_hresp_i;
  assign m0_hrdata_o    = s_hrdata_i;
  assign m1_hrdata_o    = s_hrdata_i;

endmodule

// File: tb/tb_ahb_lite_dual_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ahb_lite_dual_master_arbiter
//
// Directed bench for ahb_lite_dual_master_arbiter. Inputs change 1 time unit
// after the rising edge. Outputs are sampled on the falling edge. The
// downstream slave is modelled by driving s_hreadyout_i/s_hresp_i/s_hrdata_i
// directly in each scenario.
//
// status = {m0_hreadyout, m1_hreadyout, m0_hresp, m1_hresp, s_hsel, s_htrans}
// -----------------------------------------------------------------------------
module tb_ahb_lite_dual_master_arbiter;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;

  logic        hclk_i;
  logic        hreset_ni;
  logic [31:0] m0_haddr, m1_haddr;
  logic [1:0]  m0_htrans, m1_htrans;
  logic        m0_hwrite, m1_hwrite;
  logic [2:0]  m0_hsize, m1_hsize;
  logic [63:0] m0_hwdata, m1_hwdata;
  logic        m0_hreadyout, m1_hreadyout;
  logic        m0_hresp, m1_hresp;
  logic [63:0] m0_hrdata, m1_hrdata;
  logic        s_hsel;
  logic [31:0] s_haddr;
  logic [1:0]  s_htrans;
  logic        s_hwrite;
  logic [2:0]  s_hsize;
  logic [63:0] s_hwdata;
  logic        s_hready;
  logic        s_hreadyout;
  logic        s_hresp;
  logic [63:0] s_hrdata;

  logic [6:0]  status;
  assign status = {m0_hreadyout, m1_hreadyout, m0_hresp, m1_hresp, s_hsel, s_htrans};

  int tests_run;
  int tests_failed;

  ahb_lite_dual_master_arbiter #(
    .AHB_ADDR_WIDTH(32),
    .AHB_DATA_WIDTH(64)
  ) dut (
    .hclk_i         (hclk_i),
    .hreset_ni      (hreset_ni),
    .m0_haddr_i     (m0_haddr),
    .m0_htrans_i    (m0_htrans),
    .m0_hwrite_i    (m0_hwrite),
    .m0_hsize_i     (m0_hsize),
    .m0_hwdata_i    (m0_hwdata),
    .m0_hreadyout_o (m0_hreadyout),
    .m0_hresp_o     (m0_hresp),
    .m0_hrdata_o    (m0_hrdata),
    .m1_haddr_i     (m1_haddr),
    .m1_htrans_i    (m1_htrans),
    .m1_hwrite_i    (m1_hwrite),
    .m1_hsize_i     (m1_hsize),
    .m1_hwdata_i    (m1_hwdata),
    .m1_hreadyout_o (m1_hreadyout),
    .m1_hresp_o     (m1_hresp),
    .m1_hrdata_o    (m1_hrdata),
    .s_hsel_o       (s_hsel),
    .s_haddr_o      (s_haddr),
    .s_htrans_o     (s_htrans),
    .s_hwrite_o     (s_hwrite),
    .s_hsize_o      (s_hsize),
    .s_hwdata_o     (s_hwdata),
    .s_hready_o     (s_hready),
    .s_hreadyout_i  (s_hreadyout),
    .s_hresp_i      (s_hresp),
    .s_hrdata_i     (s_hrdata)
  );

  initial hclk_i = 1'b0;
  always #5 hclk_i = ~hclk_i;

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge hclk_i);
    #1;
  endtask

  task automatic drive_m0(input logic [1:0] trans, input logic [31:0] addr,
                          input logic wr, input logic [2:0] size);
    m0_htrans = trans; m0_haddr = addr; m0_hwrite = wr; m0_hsize = size;
  endtask

  task automatic drive_m1(input logic [1:0] trans, input logic [31:0] addr,
                          input logic wr, input logic [2:0] size);
    m1_htrans = trans; m1_haddr = addr; m1_hwrite = wr; m1_hsize = size;
  endtask

  task automatic pulse_reset();
    hreset_ni = 1'b0;
    next_cycle();
    hreset_ni = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    hreset_ni = 1'b0;
    drive_m0(IDLE, 32'h0, 1'b0, 3'd0);
    drive_m1(IDLE, 32'h0, 1'b0, 3'd0);
    m0_hwdata = '0; m1_hwdata = '0;
    s_hreadyout = 1'b1; s_hresp = 1'b0; s_hrdata = '0;
    #3;
    tests_run++;
    if (status !== 7'b1100000) begin tests_failed++; $display("FAIL reset_status: got %b exp %b", status, 7'b1100000); end
    next_cycle();
    next_cycle();
    hreset_ni = 1'b1;
    // IDLE and BUSY from M0 must never be captured.
    for (int i = 0; i < 4; i++) begin
      drive_m0((i % 2 == 0) ? BUSY : IDLE, 32'h0000_0400, 1'b1, 3'd2);
      @(negedge hclk_i);
      tests_run++;
      if (status !== 7'b1100000) begin tests_failed++; $display("FAIL idle_busy_ignored[%0d]: got %b exp %b", i, status, 7'b1100000); end
      next_cycle();
    end
    drive_m0(IDLE, 32'h0, 1'b0, 3'd0);
  endtask

  task automatic test_single_write();
    // Cycle N: address phase from M0.
    drive_m0(NONSEQ, 32'h0000_1000, 1'b1, 3'd2);
    @(negedge hclk_i);
    tests_run++;
    if (status !== 7'b1100000) begin tests_failed++; $display("FAIL wr_n_status: got %b exp %b", status, 7'b1100000); end
    next_cycle();
    // N+1: downstream address phase, M0 stalled.
    drive_m0(IDLE, 32'h0, 1'b0, 3'd0);
    m0_hwdata = 64'h0000_0000_0000_A5A5;
    @(negedge hclk_i);
    tests_run++;
    if (status !== 7'b0100110) begin tests_failed++; $display("FAIL wr_n1_status: got %b exp %b", status, 7'b0100110); end
    tests_run++;
    if (s_haddr !== 32'h0000_1000) begin tests_failed++; $display("FAIL wr_n1_haddr: got %h exp %h", s_haddr, 32'h0000_1000); end
    tests_run++;
    if ({s_hwrite, s_hsize} !== 4'b1010) begin tests_failed++; $display("FAIL wr_n1_ctrl: got %b exp %b", {s_hwrite, s_hsize}, 4'b1010); end
    next_cycle();
    // N+2: downstream data phase, M0 completes.
    @(negedge hclk_i);
    tests_run++;
    if (status !== 7'b1100000) begin tests_failed++; $display("FAIL wr_n2_status: got %b exp %b", status, 7'b1100000); end
    tests_run++;
    if (s_hwdata !== 64'h0000_0000_0000_A5A5) begin tests_failed++; $display("FAIL wr_n2_hwdata: got %h exp %h", s_hwdata, 64'hA5A5); end
    next_cycle();
    m0_hwdata = '0;
    @(negedge hclk_i);
    tests_run++;
    if (s_hwdata !== 64'h0) begin tests_failed++; $display("FAIL wr_n3_hwdata_idle: got %h exp %h", s_hwdata, 64'h0); end
    next_cycle();
  endtask

  task automatic test_round_robin();
    pulse_reset();  // pointer back to M0
    // Pair A: both captured together, M0 wins.
    drive_m0(NONSEQ, 32'h10, 1'b0, 3'd3);
    drive_m1(NONSEQ, 32'h20, 1'b0, 3'd3);
    next_cycle();
    drive_m0(IDLE, 32'h0, 1'b0, 3'd0);
    drive_m1(IDLE, 32'h0, 1'b0, 3'd0);
    @(negedge hclk_i);
    tests_run++;
    if (status !== 7'b0000110 || s_haddr !== 32'h10) begin tests_failed++; $display("FAIL rr_a_first: got %b/%h exp %b/%h", status, s_haddr, 7'b0000110, 32'h10); end
    next_cycle();
    s_hrdata = 64'h1111;
    @(negedge hclk_i);
    tests_run++;
    if (status !== 7'b1000110 || s_haddr !== 32'h20) begin tests_failed++; $display("FAIL rr_a_second: got %b/%h exp %b/%h", status, s_haddr, 7'b1000110, 32'h20); end
    tests_run++;
    if (m0_hrdata !== 64'h1111) begin tests_failed++; $display("FAIL rr_a_m0_rdata: got %h exp %h", m0_hrdata, 64'h1111); end
    next_cycle();
    s_hrdata = 64'h2222;
    @(negedge hclk_i);
    tests_run++;
    if (status !== 7'b1100000 || m1_hrdata !== 64'h2222) begin tests_failed++; $display("FAIL rr_a_m1_done: got %b/%h exp %b/%h", status, m1_hrdata, 7'b1100000, 64'h2222); end
    next_cycle();
    s_hrdata = '0;
    // M0 alone: it becomes the most recent grant.
    drive_m0(NONSEQ, 32'h30, 1'b0, 3'd3);
    next_cycle();
    drive_m0(IDLE, 32'h0, 1'b0, 3'd0);
    @(negedge hclk_i);
    tests_run++;
    if (status !== 7'b0100110 || s_haddr !== 32'h30) begin tests_failed++; $display("FAIL rr_single_m0: got %b/%h exp %b/%h", status, s_haddr, 7'b0100110, 32'h30); end
    next_cycle();
    next_cycle();
    // Pair B: M0 was granted last, so M1 wins.
    drive_m0(NONSEQ, 32'h40, 1'b0, 3'd3);
    drive_m1(NONSEQ, 32'h50, 1'b0, 3'd3);
    next_cycle();
    drive_m0(IDLE, 32'h0, 1'b0, 3'd0);
    drive_m1(IDLE, 32'h0, 1'b0, 3'd0);
    @(negedge hclk_i);
    tests_run++;
    if (status !== 7'b0000110 || s_haddr !== 32'h50) begin tests_failed++; $display("FAIL rr_b_first: got %b/%h exp %b/%h", status, s_haddr, 7'b0000110, 32'h50); end
    next_cycle();
    @(negedge hclk_i);
    tests_run++;
    if (status !== 7'b0100110 || s_haddr !== 32'h40) begin tests_failed++; $display("FAIL rr_b_second: got %b/%h exp %b/%h", status, s_haddr, 7'b0100110, 32'h40); end
    next_cycle();
    @(negedge hclk_i);
    tests_run++;
    if (status !== 7'b1100000) begin tests_failed++; $display("FAIL rr_b_done: got %b exp %b", status, 7'b1100000); end
    next_cycle();
  endtask

  task automatic test_wait_states();
    drive_m1(NONSEQ, 32'h80, 1'b0, 3'd3);
    next_cycle();
    drive_m1(IDLE, 32'h0, 1'b0, 3'd0);
    drive_m0(NONSEQ, 32'h90, 1'b1, 3'd3);
    @(negedge hclk_i);
    tests_run++;
    if (status !== 7'b1000110 || s_haddr !== 32'h80) begin tests_failed++; $display("FAIL ws_m1_aph: got %b/%h exp %b/%h", status, s_haddr, 7'b1000110, 32'h80); end
    next_cycle();
    // M1 in dph, M0 in aph. The slave inserts 3 wait states.
    drive_m0(IDLE, 32'h0, 1'b0, 3'd0);
    m0_hwdata = 64'h9999;
    s_hreadyout = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge hclk_i);
      tests_run++;
      if (status !== 7'b0000110 || s_haddr !== 32'h90 || s_hready !== 1'b0) begin
        tests_failed++;
        $display("FAIL ws_stable[%0d]: got %b/%h/%b exp %b/%h/0", i, status, s_haddr, s_hready, 7'b0000110, 32'h90);
      end
      next_cycle();
    end
    s_hreadyout = 1'b1;
    s_hrdata = 64'hDEAD_BEEF_CAFE_F00D;
    @(negedge hclk_i);
    tests_run++;
    if (status !== 7'b0100110 || s_haddr !== 32'h90) begin tests_failed++; $display("FAIL ws_m1_release: got %b/%h exp %b/%h", status, s_haddr, 7'b0100110, 32'h90); end
    tests_run++;
    if (m1_hrdata !== 64'hDEAD_BEEF_CAFE_F00D) begin tests_failed++; $display("FAIL ws_m1_rdata: got %h exp %h", m1_hrdata, 64'hDEAD_BEEF_CAFE_F00D); end
    next_cycle();
    s_hrdata = '0;
    @(negedge hclk_i);
    tests_run++;
    if (status !== 7'b1100000 || s_hwdata !== 64'h9999) begin tests_failed++; $display("FAIL ws_m0_done: got %b/%h exp %b/%h", status, s_hwdata, 7'b1100000, 64'h9999); end
    next_cycle();
    m0_hwdata = '0;
  endtask

  task automatic test_error();
    drive_m0(NONSEQ, 32'hE0, 1'b1, 3'd2);
    next_cycle();
    drive_m0(IDLE, 32'h0, 1'b0, 3'd0);
    m0_hwdata = 64'hEEEE;
    drive_m1(NONSEQ, 32'hF0, 1'b0, 3'd2);
    @(negedge hclk_i);
    tests_run++;
    if (status !== 7'b0100110 || s_haddr !== 32'hE0) begin tests_failed++; $display("FAIL err_aph: got %b/%h exp %b/%h", status, s_haddr, 7'b0100110, 32'hE0); end
    next_cycle();
    // First ERROR cycle: hresp=1, hready=0.
    drive_m1(IDLE, 32'h0, 1'b0, 3'd0);
    s_hreadyout = 1'b0; s_hresp = 1'b1;
    @(negedge hclk_i);
    tests_run++;
    if (status !== 7'b0010110 || s_haddr !== 32'hF0) begin tests_failed++; $display("FAIL err_cycle1: got %b/%h exp %b/%h", status, s_haddr, 7'b0010110, 32'hF0); end
    next_cycle();
    // Second ERROR cycle: hresp=1, hready=1.
    s_hreadyout = 1'b1;
    @(negedge hclk_i);
    tests_run++;
    if (status !== 7'b1010110 || s_haddr !== 32'hF0) begin tests_failed++; $display("FAIL err_cycle2: got %b/%h exp %b/%h", status, s_haddr, 7'b1010110, 32'hF0); end
    next_cycle();
    // The M1 read queued behind the error still completes normally.
    s_hresp = 1'b0;
    m0_hwdata = '0;
    @(negedge hclk_i);
    tests_run++;
    if (status !== 7'b1100000) begin tests_failed++; $display("FAIL err_m1_done: got %b exp %b", status, 7'b1100000); end
    next_cycle();
  endtask

  task automatic test_reset_mid_transfer();
    drive_m1(NONSEQ, 32'hC0, 1'b0, 3'd2);
    next_cycle();
    drive_m1(IDLE, 32'h0, 1'b0, 3'd0);
    @(negedge hclk_i);
    tests_run++;
    if (status !== 7'b1000110) begin tests_failed++; $display("FAIL rst_mid_aph: got %b exp %b", status, 7'b1000110); end
    next_cycle();
    s_hreadyout = 1'b0;  // hold M1 in its data phase
    @(negedge hclk_i);
    tests_run++;
    if (status !== 7'b1000000) begin tests_failed++; $display("FAIL rst_mid_dph: got %b exp %b", status, 7'b1000000); end
    #2;
    hreset_ni = 1'b0;
    #1;
    tests_run++;
    if (status !== 7'b1100000) begin tests_failed++; $display("FAIL rst_mid_async: got %b exp %b", status, 7'b1100000); end
    next_cycle();
    s_hreadyout = 1'b1;
    hreset_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge hclk_i);
      tests_run++;
      if (status !== 7'b1100000) begin tests_failed++; $display("FAIL rst_mid_after[%0d]: got %b exp %b", i, status, 7'b1100000); end
      next_cycle();
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_wait_states();
    test_error();
    test_reset_mid_transfer();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
